// File: rtl/mm_pkg.sv
// Shared definitions for the mm memory and its program loader.
package mm_pkg;

  localparam int MM_ADDR_W = 4;
  localparam int MM_DATA_W = 8;
  localparam int MM_DEPTH  = 16;

  // Loader session phases: waiting, length byte, payload, checksum byte.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } ldr_state_t;

endpackage

// File: rtl/mm_loader.sv
// Framed byte-stream loader: LEN, LEN data bytes, CSUM. Data bytes are
// written to consecutive mm addresses starting at 0 through a registered
// write port. The session ends with a done pulse. err is set when the frame
// fails its checks and is held until the next start.
module mm_loader
  import mm_pkg::*;
#(
  parameter int ADDR_W = MM_ADDR_W,
  parameter int DATA_W = MM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [DATA_W-1:0] MAX_LEN = DATA_W'(2 ** ADDR_W);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

  ldr_state_t        state_r;
  logic [DATA_W-1:0] acc_r;
  logic [ADDR_W:0]   len_r;
  logic [DATA_W-1:0] sum_s;
  logic [ADDR_W:0]   next_count_s;
  logic              accept_s;

  // The frame length must fit the memory, and an empty frame is not allowed.
  function automatic logic len_ok(input logic [DATA_W-1:0] len);
    return (len != {DATA_W{1'b0}}) && (len <= MAX_LEN);
  endfunction

  // The handshake state and the session flag come straight from the state register.
  assign s_ready  = (state_r != IDLE);
  assign busy     = (state_r != IDLE);
  assign accept_s = s_valid && s_ready;

  // Running checksum including the incoming byte, and the next write count.
  always_comb begin
    sum_s        = acc_r + s_data;
    next_count_s = count + CNT_ONE;
  end

  // Session FSM with the write port, the counter and the checksum accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      acc_r   <= {DATA_W{1'b0}};
      len_r   <= {(ADDR_W + 1){1'b0}};
      waddr   <= {ADDR_W{1'b0}};
      wdata   <= {DATA_W{1'b0}};
      we      <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      count   <= {(ADDR_W + 1){1'b0}};
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= LEN;
            err     <= 1'b0;
            count   <= {(ADDR_W + 1){1'b0}};
            acc_r   <= {DATA_W{1'b0}};
            len_r   <= {(ADDR_W + 1){1'b0}};
          end
        end
        LEN: begin
          if (accept_s) begin
            acc_r <= s_data;
            if (len_ok(s_data)) begin
              len_r   <= s_data[ADDR_W:0];
              state_r <= DATA;
            end else begin
              // A rejected length ends the session without touching memory.
              err     <= 1'b1;
              done    <= 1'b1;
              state_r <= IDLE;
            end
          end
        end
        DATA: begin
          if (accept_s) begin
            acc_r <= sum_s;
            waddr <= count[ADDR_W-1:0];
            wdata <= s_data;
            we    <= 1'b1;
            count <= next_count_s;
            if (next_count_s == len_r) begin
              state_r <= CSUM;
            end
          end
        end
        CSUM: begin
          if (accept_s) begin
            // Writes already issued stay in memory even when the checksum fails.
            acc_r   <= sum_s;
            err     <= (sum_s != {DATA_W{1'b0}});
            done    <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_loader.sv
// Self-checking bench for mm_loader: fixed frames from the test plan plus
// randomized frames, checked against a frame-level model of the loader.
module tb_mm_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] waddr;
  logic [7:0] wdata;
  logic       we;
  logic       busy;
  logic       done;
  logic       err;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;

  mm_loader dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .waddr  (waddr),
    .wdata  (wdata),
    .we     (we),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .count  (count)
  );

  always #5 clk = ~clk;

  // Memory image seen on the write port, plus write/done statistics.
  logic [7:0] mem_obs [16];
  int we_count, done_count, orphan, cur_run, max_run;
  bit prev_acc;

  always @(negedge clk) begin
    if (rst_n) begin
      if (we) begin
        mem_obs[waddr] <= wdata;
        we_count <= we_count + 1;
        cur_run  <= cur_run + 1;
        if (cur_run + 1 > max_run) max_run <= cur_run + 1;
        if (!prev_acc) orphan <= orphan + 1;
      end else begin
        cur_run <= 0;
      end
      if (done) done_count <= done_count + 1;
      prev_acc <= s_valid && s_ready;
    end else begin
      cur_run  <= 0;
      prev_acc <= 1'b0;
    end
  end

  logic [7:0] frame_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until it is accepted (bounded wait).
  task automatic push(input logic [7:0] b);
    int t = 0;
    s_data  = b;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout byte %02h never accepted", b);
    end
    tick();
    s_valid = 1'b0;
  endtask

  // Run one session of frame_q and check it against the frame-level model.
  task automatic run_session(input string name, input int gap, input bit mid_start);
    int  len, sum, exp_count;
    bit  bad_len, exp_err;
    len     = int'(frame_q[0]);
    bad_len = (len == 0) || (len > 16);
    sum     = 0;
    foreach (frame_q[i]) sum += int'(frame_q[i]);
    exp_err   = bad_len || ((sum % 256) != 0);
    exp_count = bad_len ? 0 : len;

    for (int i = 0; i < 16; i++) mem_obs[i] = 8'hxx;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL %s idle_s_ready got %0b want 0", name, s_ready); end

    start = 1'b1;
    tick();
    start = 1'b0;
    we_count = 0; done_count = 0; orphan = 0; cur_run = 0; max_run = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got %0b want 1", name, busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL %s err_cleared got %0b want 0", name, err); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL %s count_cleared got %0d want 0", name, count); end

    foreach (frame_q[i]) begin
      push(frame_q[i]);
      if (i != frame_q.size() - 1) begin
        for (int g = 0; g < gap; g++) begin
          if (mid_start && i == 1 && g == 0) start = 1'b1;
          tick();
          start = 1'b0;
        end
      end
    end

    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s done_pulse got %0b want 1", name, done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_end got %0b want 0", name, busy); end
    checks++; if (err !== exp_err) begin errors++; $display("FAIL %s err got %0b want %0b", name, err, exp_err); end
    checks++; if (count !== 5'(exp_count)) begin errors++; $display("FAIL %s count got %0d want %0d", name, count, exp_count); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_width got %0b want 0", name, done); end
    checks++; if (err !== exp_err) begin errors++; $display("FAIL %s err_hold got %0b want %0b", name, err, exp_err); end
    checks++; if (we_count !== exp_count) begin errors++; $display("FAIL %s we_pulses got %0d want %0d", name, we_count, exp_count); end
    checks++; if (orphan !== 0) begin errors++; $display("FAIL %s we_without_accept got %0d want 0", name, orphan); end
    checks++; if (done_count !== 1) begin errors++; $display("FAIL %s done_count got %0d want 1", name, done_count); end
    if (gap == 0) begin
      checks++; if (max_run !== exp_count) begin errors++; $display("FAIL %s we_run got %0d want %0d", name, max_run, exp_count); end
    end
    for (int i = 0; i < exp_count; i++) begin
      checks++;
      if (mem_obs[i] !== frame_q[1 + i]) begin
        errors++;
        $display("FAIL %s mem[%0d] got %02h want %02h", name, i, mem_obs[i], frame_q[1 + i]);
      end
    end
  endtask

  task automatic load_basic(input logic [7:0] csum);
    frame_q = '{8'h03, 8'hA5, 8'h3C, 8'hFF, csum};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    #7;
    checks++; if ({s_ready, we, busy, done, err} !== 5'b0) begin errors++; $display("FAIL reset_flags got %05b want 00000", {s_ready, we, busy, done, err}); end
    checks++; if ({waddr, wdata, count} !== 17'd0) begin errors++; $display("FAIL reset_regs got %05h want 0", {waddr, wdata, count}); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if ({s_ready, we, busy, done, err, count} !== 10'd0) begin errors++; $display("FAIL reset_release got %03h want 0", {s_ready, we, busy, done, err, count}); end
  endtask

  task automatic test_basic();
    load_basic(8'h1D);
    run_session("basic", 0, 1'b0);
  endtask

  task automatic test_full();
    frame_q = '{8'h10};
    for (int i = 0; i < 16; i++) frame_q.push_back(8'(i * 3));
    frame_q.push_back(8'h88);
    run_session("full", 0, 1'b0);
  endtask

  task automatic test_bad_checksum();
    load_basic(8'h00);
    run_session("bad_csum", 0, 1'b0);
    repeat (3) tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_csum_err_held got %0b want 1", err); end
    load_basic(8'h1D);
    run_session("after_bad_csum", 0, 1'b0);
  endtask

  task automatic test_bad_length();
    frame_q = '{8'h00};
    run_session("bad_len_00", 0, 1'b0);
    frame_q = '{8'h11};
    run_session("bad_len_11", 0, 1'b0);
  endtask

  task automatic test_flow_control();
    load_basic(8'h1D);
    run_session("flow", 2, 1'b1);
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 16; i++) mem_obs[i] = 8'hxx;
    start = 1'b1;
    tick();
    start = 1'b0;
    we_count = 0;
    push(8'h03);
    push(8'hA5);
    push(8'h3C);
    tick();
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL midop_count_before got %0d want 2", count); end
    rst_n = 1'b0;
    #1;
    checks++; if ({we, busy, done, s_ready} !== 4'b0) begin errors++; $display("FAIL midop_flags got %04b want 0000", {we, busy, done, s_ready}); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL midop_count got %0d want 0", count); end
    checks++; if (we_count !== 2) begin errors++; $display("FAIL midop_writes got %0d want 2", we_count); end
    checks++; if (mem_obs[0] !== 8'hA5 || mem_obs[1] !== 8'h3C) begin errors++; $display("FAIL midop_mem got %02h %02h want a5 3c", mem_obs[0], mem_obs[1]); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    load_basic(8'h1D);
    run_session("after_reset", 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int len, sum, gap;
      logic [7:0] b;
      gap = int'($urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(17, 255));
        frame_q = '{8'(len)};
      end else begin
        len = int'($urandom_range(1, 16));
        frame_q = '{8'(len)};
        sum = len;
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom_range(0, 255));
          frame_q.push_back(b);
          sum += int'(b);
        end
        b = 8'((256 - (sum % 256)) % 256);
        if ($urandom_range(0, 3) == 0) b = b ^ 8'($urandom_range(1, 255));
        frame_q.push_back(b);
      end
      run_session("random", gap, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_bad_checksum();
    test_bad_length();
    test_flow_control();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_loader.md
# mm_loader

Byte-stream program loader that sits directly upstream of the `mm` 16×8 memory and drives its write port (`waddr`/`wdata`/`we`). It accepts a framed byte stream over a valid/ready handshake: a length byte, then that many data bytes written to consecutive addresses starting at 0, then a checksum byte. It reports completion and integrity status so the core can be held in reset or stalled until the image is loaded.

## Interface
Parameters:
- `ADDR_W`, 4: address width; max frame length is 2**ADDR_W.
- `DATA_W`, 8: byte/word width; must match `mm`.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load session; sampled only in IDLE.
- `s_data`  in  DATA_W  stream byte.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `waddr`  out  ADDR_W  memory write address, to `mm.waddr`.
- `wdata`  out  DATA_W  memory write data, to `mm.wdata`.
- `we`  out  1  memory write enable, to `mm.we`.
- `busy`  out  1  session in progress.
- `done`  out  1  one-cycle pulse at session end.
- `err`  out  1  session ended in error; held until next accepted `start`.
- `count`  out  ADDR_W+1  data bytes written in current/last session.

## Operation
- Reset: state IDLE; `s_ready`, `we`, `busy`, `done`, `err` = 0; `waddr`, `wdata`, `count` = 0; checksum accumulator = 0.
- A byte is accepted on any edge where `s_valid && s_ready`.
- `s_ready` = 1 in LEN, DATA, CSUM; 0 in IDLE.
- States:
  - IDLE: `start` → LEN; clears `err`, `count`, accumulator, address pointer.
  - LEN: accept byte L. If 1 ≤ L ≤ 2**ADDR_W → DATA; else → IDLE with `err`=1 and `done` pulse, no writes.
  - DATA: each accepted byte issues one write at the current pointer, then the pointer and `count` increment. After L bytes → CSUM.
  - CSUM: accept byte C. Go to IDLE and pulse `done`. `err` = 1 if (L + Σdata + C) mod 2**DATA_W ≠ 0.
- The accumulator adds every accepted byte (LEN, DATA, CSUM) modulo 2**DATA_W.
- A checksum failure does not undo writes; memory holds the received data.
- `start` while not in IDLE is ignored.
- `busy` = (state ≠ IDLE).
- Address pointer never wraps within a session because L ≤ 2**ADDR_W. For L = 16, `count` reaches 16 (5-bit).

## Timing
- `start` high at edge k in IDLE: `busy`=1 from cycle k+1. The LEN byte is acceptable from cycle k+1.
- Write path is registered:
  - Data byte accepted at edge k: `waddr`/`wdata`/`we`=1 are valid during cycle k+1, and `mm` writes at edge k+1.
  - `we` is high for exactly one cycle per accepted data byte.
  - Back-to-back acceptance gives `we` high on consecutive cycles, so full throughput is 1 byte/cycle.
- `s_valid` low cycles insert gaps. `we` = 0 in those cycles; `wdata`/`waddr` hold their last values.
- CSUM (or a bad LEN) accepted at edge k: `done`=1, `busy`=0, and `err` is final in cycle k+1. `done` returns to 0 at k+2.
- The minimum session for L data bytes is L+2 accepted bytes. `done` comes 1 cycle after the last byte.
- Reset asserted mid-session: all outputs go to reset values immediately (async), including `we`=0, so no partial write is issued. Memory contents already written are untouched. After reset release, a new `start` begins a clean session.

## Structure
- Shared package `mm_pkg`:
  - `MM_ADDR_W`=4, `MM_DATA_W`=8, `MM_DEPTH`=16; used by both `mm` and `mm_loader`.
  - Loader state enum `ldr_state_t` {IDLE, LEN, DATA, CSUM}.
- Single module, no sub-module; FSM, pointer/counter, and accumulator inline.
- Integration bench instantiates `mm_loader` driving `mm`, and checks memory via `mm` read ports.

## Test plan
- **Basic frame:** stream 03, A5, 3C, FF, 1D back-to-back. Required: `we` high 3 consecutive cycles; mm[0]=A5, mm[1]=3C, mm[2]=FF; `done` pulse; `err`=0; `count`=3.
- **Full frame:** stream 10, then i*3 for i=0..15, then 88. Required: mm[i]=i*3 for all 16 addresses; `count`=16; `err`=0.
- **Bad checksum:** frame of test 1 with checksum 00. Required: mm[0..2] written as in test 1; `done` pulse; `err`=1 until next `start`.
- **Bad length:** LEN=00, then separately LEN=11. Required: no `we` pulses; `done` 1 cycle after the LEN byte; `err`=1.
- **Flow control:** test 1 with `s_valid` low 2 cycles between each byte; `start` pulsed mid-session. Required: `we` only in cycles after accepts; same final memory; extra `start` ignored; `s_ready`=0 while IDLE.
- **Reset mid-op:** assert `rst_n`=0 after 2 data bytes of a 5-byte frame. Required: `we`/`busy`/`count` go to 0 immediately; mm[0..1] keep their values; a following full test-1 frame completes with `err`=0.
